pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. Generates the 6-bit stall vector and the IF/ID and ID/EX flush strobes consumed by the stage registers. Inputs are load-use hazards, taken branches, and memory-busy requests from IF and MEM. Holds a pending-flush FSM so a branch redirect is never lost under a MEM stall, plus a stall watchdog and performance counters.

Parameters:
CNT_W, 32, width of the perf counters stall_cycles and flush_count.
TIMEOUT, 1024, number of consecutive mem_stallreq cycles before wd_err is set.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
id_reg1_read  in  1  the ID instruction reads rs1
id_reg1_addr  in  5  rs1 address
id_reg2_read  in  1  the ID instruction reads rs2
id_reg2_addr  in  5  rs2 address
ex_now_load  in  1  the EX stage holds a load
ex_wd  in  5  destination register of the EX instruction
ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
if_stallreq  in  1  instruction fetch not yet returned
mem_stallreq  in  1  MEM stage data access not complete
stall  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB; 1=Stop
if_idflush_o  out  1  clear the IF/ID register at the next edge
id_exflush_o  out  1  clear the ID/EX register at the next edge
wd_err  out  1  sticky watchdog error
stall_cycles  out  CNT_W  cycles in which stall!=0
flush_count  out  CNT_W  number of flushes issued

Behaviour:
- Reset, rst=0, asynchronous:
  - FSM goes to S_RUN.
  - stall=0, both flushes=0, wd_err=0, counters=0, watchdog count=0.
- Stage-register rule: a register inserts a bubble when its upstream stall bit is Stop and its own bit is NoStop.
- load_use = ex_now_load & ex_wd!=0 & ((id_reg1_read & id_reg1_addr==ex_wd) | (id_reg2_read & id_reg2_addr==ex_wd)).
- Stall and flush outputs are combinational from the inputs and the FSM state, so they take effect at the same-cycle edge.
- Priority, highest first:
  - mem_stallreq: stall=6'b011111. Flushes are suppressed.
  - Flush due (ex_branch_taken, or state S_FLUSH_PEND): if_idflush_o=id_exflush_o=1, stall=0. The flush overrides load_use and if_stallreq, because the younger instructions are dead.
  - load_use: stall=6'b000011. One bubble enters EX. The hazard clears on its own the next cycle.
  - if_stallreq: stall=6'b000001. The PC holds and IF/ID takes a bubble.
  - Otherwise: stall=0.
- FSM states:
  - S_RUN:
    - mem_stallreq & ex_branch_taken -> S_FLUSH_PEND.
    - mem_stallreq alone -> S_MEM_WAIT.
  - S_MEM_WAIT:
    - ex_branch_taken observed -> S_FLUSH_PEND.
    - mem_stallreq=0 -> S_RUN.
  - S_FLUSH_PEND:
    - Stay while mem_stallreq=1.
    - On the first cycle with mem_stallreq=0: drive the flush and return to S_RUN.
    - If ex_branch_taken is also high that cycle, it merges into this single flush, and flush_count increments once.
- Watchdog:
  - The counter increments each consecutive cycle mem_stallreq=1 and clears when it is 0.
  - When the count reaches TIMEOUT-1 while mem_stallreq is still 1, wd_err sets and stays set until reset.
  - The counter saturates; it does not wrap.
- Perf counters:
  - stall_cycles increments on every cycle with stall!=0.
  - flush_count increments on every cycle the flush is driven.
  - Both wrap modulo 2^CNT_W.
- Reset asserted mid-stall or in S_FLUSH_PEND discards the pending flush.

Decomposition:
- Shared defines header:
  - Stop and NoStop values.
  - Stall-vector constants STALL_NONE, STALL_IF, STALL_LOADUSE, STALL_MEM.
  - FSM state encodings.
  - RegAddrBus width.
- One sub-module, pipe_ctrl_wdog, holds the saturating timeout counter and the sticky wd_err.

Test Plan:
- Load-use on rs1: ex_now_load=1, ex_wd=5, id_reg1_read=1, id_reg1_addr=5 -> stall=6'b000011 for exactly 1 cycle. Repeat with ex_wd=0 -> stall=0.
- Taken branch: ex_branch_taken=1 for 1 cycle -> if_idflush_o=id_exflush_o=1 that cycle, stall=0, flush_count 0->1.
- Branch under MEM stall: mem_stallreq=1 for 4 cycles with ex_branch_taken pulsed in cycle 1 -> stall=6'b011111 with no flush for 4 cycles, then a flush in cycle 5, and state returns to S_RUN.
- Simultaneous requests: mem_stallreq=1, load_use=1, if_stallreq=1 -> stall=6'b011111. Drop mem_stallreq -> stall=6'b000011.
- Watchdog with TIMEOUT=8: mem_stallreq held for 10 cycles -> wd_err rises after the 8th cycle and stays 1 after mem_stallreq drops. stall_cycles=10.
- Reset mid-operation: assert rst=0 while in S_FLUSH_PEND -> all outputs 0 immediately, with no flush after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Holds stall encodings, FSM states, register-address width and hazard helper.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int STALL_W    = 6;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Bit order: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
  localparam logic [STALL_W-1:0] STALL_NONE = {
    NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP
  };
  localparam logic [STALL_W-1:0] STALL_IF = {
    NOSTOP, NOSTOP, NOSTOP, NOSTOP, NOSTOP, STOP
  };
  localparam logic [STALL_W-1:0] STALL_LOADUSE = {
    NOSTOP, NOSTOP, NOSTOP, NOSTOP, STOP, STOP
  };
  localparam logic [STALL_W-1:0] STALL_MEM = {
    NOSTOP, STOP, STOP, STOP, STOP, STOP
  };

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_MEM_WAIT   = 2'd1,
    S_FLUSH_PEND = 2'd2
  } state_e;

  typedef struct packed {
    logic                  rd;
    logic [REG_ADDR_W-1:0] addr;
  } rs_t;

  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_f(
    input logic                  ex_load,
    input logic [REG_ADDR_W-1:0] ex_wd,
    input rs_t                   rs1,
    input rs_t                   rs2
  );
    logic hit1;
    logic hit2;
    hit1 = rs1.rd && (rs1.addr == ex_wd);
    hit2 = rs2.rd && (rs2.addr == ex_wd);
    return ex_load && (ex_wd != '0) && (hit1 || hit2);
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// MEM-stall watchdog: saturating count of consecutive stall cycles.
// Ports: clk_i, rst_ni, stallreq_i in; wd_err_o sticky error out.
module pipe_ctrl_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stallreq_i,
  output logic wd_err_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_q;
  logic          err_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (!stallreq_i) begin
      cnt_d = '0;
    end else begin
      if (!at_last) begin
        cnt_d = cnt_q + CW'(1);
      end
      // TIMEOUT-1 completed cycles plus this one still stalled.
      if (at_last) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign wd_err_o = err_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// In: hazards, branch, IF/MEM busy. Out: stall, flushes, wd_err, perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_reg1_read,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr,
  input  logic                  id_reg2_read,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr,
  input  logic                  ex_now_load,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_branch_taken,
  input  logic                  if_stallreq,
  input  logic                  mem_stallreq,
  output logic [STALL_W-1:0]    stall,
  output logic                  if_idflush_o,
  output logic                  id_exflush_o,
  output logic                  wd_err,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  state_e state_q;
  state_e state_d;

  rs_t rs1;
  rs_t rs2;

  logic load_use;
  logic flush_due;
  logic sel_flush;
  logic sel_lu;
  logic sel_if;

  logic [STALL_W-1:0] stall_c;
  logic               flush_c;

  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q;
  logic [CNT_W-1:0] flush_count_d;

  assign rs1 = '{rd: id_reg1_read, addr: id_reg1_addr};
  assign rs2 = '{rd: id_reg2_read, addr: id_reg2_addr};

  assign load_use = load_use_f(ex_now_load, ex_wd, rs1, rs2);

  // A branch seen during FLUSH_PEND merges into the pending flush.
  assign flush_due = ex_branch_taken || (state_q == S_FLUSH_PEND);

  // Mutually exclusive selects encode the priority order.
  assign sel_flush = !mem_stallreq && flush_due;
  assign sel_lu    = !mem_stallreq && !flush_due && load_use;
  assign sel_if    = !mem_stallreq && !flush_due && !load_use
                     && if_stallreq;

  always_comb begin
    stall_c = STALL_NONE;
    flush_c = 1'b0;
    unique case (1'b1)
      mem_stallreq: stall_c = STALL_MEM;
      sel_flush:    flush_c = 1'b1;
      sel_lu:       stall_c = STALL_LOADUSE;
      sel_if:       stall_c = STALL_IF;
      default:      ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_stallreq && ex_branch_taken) begin
          state_d = S_FLUSH_PEND;
        end else if (mem_stallreq) begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        // Branch with MEM released is flushed directly this cycle.
        if (!mem_stallreq) begin
          state_d = S_RUN;
        end else if (ex_branch_taken) begin
          state_d = S_FLUSH_PEND;
        end
      end
      S_FLUSH_PEND: begin
        if (!mem_stallreq) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_c != STALL_NONE) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (flush_c) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  pipe_ctrl_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i      (clk),
    .rst_ni     (rst),
    .stallreq_i (mem_stallreq),
    .wd_err_o   (wd_err)
  );

  // Outputs are combinational; hold them quiet while reset is asserted.
  assign stall        = rst ? stall_c : STALL_NONE;
  assign if_idflush_o = rst && flush_c;
  assign id_exflush_o = rst && flush_c;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl.
// Hand-computed expectations per scenario task.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_reg1_read;
  logic [4:0]  id_reg1_addr;
  logic        id_reg2_read;
  logic [4:0]  id_reg2_addr;
  logic        ex_now_load;
  logic [4:0]  ex_wd;
  logic        ex_branch_taken;
  logic        if_stallreq;
  logic        mem_stallreq;
  logic [5:0]  stall;
  logic        if_idflush_o;
  logic        id_exflush_o;
  logic        wd_err;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int n_cmp;
  int n_bad;

  pipe_ctrl #(
    .CNT_W   (32),
    .TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_read    (id_reg1_read),
    .id_reg1_addr    (id_reg1_addr),
    .id_reg2_read    (id_reg2_read),
    .id_reg2_addr    (id_reg2_addr),
    .ex_now_load     (ex_now_load),
    .ex_wd           (ex_wd),
    .ex_branch_taken (ex_branch_taken),
    .if_stallreq     (if_stallreq),
    .mem_stallreq    (mem_stallreq),
    .stall           (stall),
    .if_idflush_o    (if_idflush_o),
    .id_exflush_o    (id_exflush_o),
    .wd_err          (wd_err),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_reg1_read    = 1'b0;
    id_reg1_addr    = 5'd0;
    id_reg2_read    = 1'b0;
    id_reg2_addr    = 5'd0;
    ex_now_load     = 1'b0;
    ex_wd           = 5'd0;
    ex_branch_taken = 1'b0;
    if_stallreq     = 1'b0;
    mem_stallreq    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (stall !== 6'b000000) begin
      n_bad++;
      $display("FAIL reset_stall got=%b exp=000000", stall);
    end
    n_cmp++;
    if ({if_idflush_o, id_exflush_o, wd_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got=%b%b%b exp=000",
               if_idflush_o, id_exflush_o, wd_err);
    end
    n_cmp++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
               stall_cycles, flush_count);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_now_load  = 1'b1;
    ex_wd        = 5'd5;
    id_reg1_read = 1'b1;
    id_reg1_addr = 5'd5;
    #1;
    n_cmp++;
    if (stall !== 6'b000011) begin
      n_bad++;
      $display("FAIL lu_rs1 got=%b exp=000011", stall);
    end
    @(negedge clk);
    ex_now_load = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 6'b000000) begin
      n_bad++;
      $display("FAIL lu_clear got=%b exp=000000", stall);
    end
    n_cmp++;
    if (stall_cycles !== 32'd1) begin
      n_bad++;
      $display("FAIL lu_cycles got=%0d exp=1", stall_cycles);
    end
    ex_now_load  = 1'b1;
    ex_wd        = 5'd0;
    id_reg1_addr = 5'd0;
    #1;
    n_cmp++;
    if (stall !== 6'b000000) begin
      n_bad++;
      $display("FAIL lu_x0 got=%b exp=000000", stall);
    end
    @(negedge clk);
    id_reg1_read = 1'b0;
    id_reg2_read = 1'b1;
    id_reg2_addr = 5'd9;
    ex_wd        = 5'd9;
    #1;
    n_cmp++;
    if (stall !== 6'b000011) begin
      n_bad++;
      $display("FAIL lu_rs2 got=%b exp=000011", stall);
    end
    id_reg2_read = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 6'b000000) begin
      n_bad++;
      $display("FAIL lu_noread got=%b exp=000000", stall);
    end
    if_stallreq = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 6'b000001) begin
      n_bad++;
      $display("FAIL if_stall got=%b exp=000001", stall);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1'b1;
    ex_now_load     = 1'b1;
    ex_wd           = 5'd3;
    id_reg1_read    = 1'b1;
    id_reg1_addr    = 5'd3;
    if_stallreq     = 1'b1;
    #1;
    n_cmp++;
    if ({if_idflush_o, id_exflush_o} !== 2'b11 || stall !== 6'd0) begin
      n_bad++;
      $display("FAIL br_flush got=%b%b stall=%b exp=11 stall=000000",
               if_idflush_o, id_exflush_o, stall);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if (flush_count !== 32'd1) begin
      n_bad++;
      $display("FAIL br_count got=%0d exp=1", flush_count);
    end
    n_cmp++;
    if ({if_idflush_o, id_exflush_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL br_after got=%b%b exp=00",
               if_idflush_o, id_exflush_o);
    end
  endtask

  task automatic test_branch_mem_stall();
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      mem_stallreq    = 1'b1;
      ex_branch_taken = (c == 1);
      #1;
      n_cmp++;
      if (stall !== 6'b011111 || if_idflush_o !== 1'b0
          || id_exflush_o !== 1'b0) begin
        n_bad++;
        $display("FAIL bm_hold c=%0d got=%b fl=%b%b exp=011111 fl=00",
                 c, stall, if_idflush_o, id_exflush_o);
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    n_cmp++;
    if ({if_idflush_o, id_exflush_o} !== 2'b11 || stall !== 6'd0) begin
      n_bad++;
      $display("FAIL bm_release got=%b%b stall=%b exp=11 stall=000000",
               if_idflush_o, id_exflush_o, stall);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({if_idflush_o, id_exflush_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL bm_run got=%b%b exp=00",
               if_idflush_o, id_exflush_o);
    end
    n_cmp++;
    if (stall_cycles !== 32'd4 || flush_count !== 32'd1) begin
      n_bad++;
      $display("FAIL bm_cnt got=%0d/%0d exp=4/1",
               stall_cycles, flush_count);
    end
    mem_stallreq    = 1'b1;
    ex_branch_taken = 1'b1;
    @(negedge clk);
    mem_stallreq    = 1'b0;
    #1;
    n_cmp++;
    if ({if_idflush_o, id_exflush_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL bm_merge got=%b%b exp=11",
               if_idflush_o, id_exflush_o);
    end
    @(negedge clk);
    ex_branch_taken = 1'b0;
    #1;
    n_cmp++;
    if (flush_count !== 32'd2 || if_idflush_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bm_merge_cnt got=%0d fl=%b exp=2 fl=0",
               flush_count, if_idflush_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    mem_stallreq = 1'b1;
    if_stallreq  = 1'b1;
    ex_now_load  = 1'b1;
    ex_wd        = 5'd7;
    id_reg2_read = 1'b1;
    id_reg2_addr = 5'd7;
    #1;
    n_cmp++;
    if (stall !== 6'b011111) begin
      n_bad++;
      $display("FAIL sim_mem got=%b exp=011111", stall);
    end
    @(negedge clk);
    mem_stallreq = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 6'b000011) begin
      n_bad++;
      $display("FAIL sim_lu got=%b exp=000011", stall);
    end
    @(negedge clk);
    ex_now_load = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 6'b000001) begin
      n_bad++;
      $display("FAIL sim_if got=%b exp=000001", stall);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if (stall !== 6'b000000 || stall_cycles !== 32'd3) begin
      n_bad++;
      $display("FAIL sim_end got=%b cyc=%0d exp=000000 cyc=3",
               stall, stall_cycles);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      mem_stallreq = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (wd_err !== (k >= 8)) begin
        n_bad++;
        $display("FAIL wd_k%0d got=%b exp=%b", k, wd_err, (k >= 8));
      end
      @(negedge clk);
    end
    mem_stallreq = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (wd_err !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_sticky got=%b exp=1", wd_err);
    end
    n_cmp++;
    if (stall_cycles !== 32'd10) begin
      n_bad++;
      $display("FAIL wd_cycles got=%0d exp=10", stall_cycles);
    end
  endtask

  task automatic test_reset_flush_pend();
    do_reset();
    mem_stallreq    = 1'b1;
    ex_branch_taken = 1'b1;
    @(negedge clk);
    ex_branch_taken = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 6'd0 || if_idflush_o !== 1'b0
        || id_exflush_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rfp_outs got=%b fl=%b%b exp=000000 fl=00",
               stall, if_idflush_o, id_exflush_o);
    end
    n_cmp++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      n_bad++;
      $display("FAIL rfp_cnt got=%0d/%0d exp=0/0",
               stall_cycles, flush_count);
    end
    @(negedge clk);
    mem_stallreq = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({if_idflush_o, id_exflush_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL rfp_noflush got=%b%b exp=00",
               if_idflush_o, id_exflush_o);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (flush_count !== 32'd0 || if_idflush_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rfp_later got=%0d fl=%b exp=0 fl=0",
               flush_count, if_idflush_o);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_branch_mem_stall();
    test_simultaneous();
    test_watchdog();
    test_reset_flush_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
